// File: rtl/obstacle_pkg.sv
// Shared definitions for the arena obstacles: state encoding, arena geometry
// defaults, colours and the sequencer's obstacle select codes.
package obstacle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARN = 2'd1,
    ST_FIRE = 2'd2,
    ST_DONE = 2'd3
  } obstacle_state_e;

  localparam int unsigned ARENA_LEFT_DEF   = 341;
  localparam int unsigned LASER_TOP_DEF    = 317;
  localparam int unsigned LASER_BOTTOM_DEF = 617;
  localparam int unsigned SCREEN_MAX_X     = 4095;

  localparam logic [11:0] COLOR_WARN_DEF = 12'hf_8_0;
  localparam logic [11:0] COLOR_FIRE_DEF = 12'hf_f_f;

  localparam logic [3:0] SEL_LASERS_SWEEP = 4'b0011;

endpackage

// File: rtl/laser_frame_timer.sv
// Frame-tick detector plus a loadable frame down-counter. tc fires on the
// frame tick that arrives while the counter has reached zero, so loading
// (frames-1) yields exactly 'frames' ticks per phase.
module laser_frame_timer
  import obstacle_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [11:0]      hcount_in,
  input  logic [11:0]      vcount_in,
  input  logic             load,
  input  logic             clr,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic             tick_q;
  logic [CNT_W-1:0] cnt_q;

  // Registered one-cycle pulse at the top-left pixel of each frame.
  always_ff @(posedge pclk) begin
    if (rst) tick_q <= 1'b0;
    else     tick_q <= (hcount_in == 12'd0) && (vcount_in == 12'd0);
  end

  // Remaining-frames counter; clear beats load, load beats counting.
  always_ff @(posedge pclk) begin
    if (rst || clr)                    cnt_q <= '0;
    else if (load)                     cnt_q <= load_val;
    else if (tick_q && (cnt_q != '0))  cnt_q <= cnt_q - 1'b1;
  end

  assign tc = tick_q && (cnt_q == '0);

endmodule

// File: rtl/lasers_sweep_obstacle.sv
// Sweeping laser obstacle: N vertical columns that warn, then fire, and shift
// right by a fixed step every round. Overlays the pixel stream and reports
// laser state to collision logic and the obstacle sequencer.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | inactive, pixels pass through, waiting for game_on + select code
// WARN  | columns drawn in warning colour, not lethal
// FIRE  | columns drawn in firing colour, laser_hot asserted
// DONE  | single cycle after the last round, done asserted
module lasers_sweep_obstacle
  import obstacle_pkg::*;
#(
  parameter int unsigned N_LASERS     = 3,
  parameter int unsigned LASER_WIDTH  = 31,
  parameter int unsigned LASER_TOP    = LASER_TOP_DEF,
  parameter int unsigned LASER_BOTTOM = LASER_BOTTOM_DEF,
  parameter int unsigned ARENA_LEFT   = ARENA_LEFT_DEF,
  parameter int unsigned SPACING      = 100,
  parameter int unsigned OFFSET_STEP  = 20,
  parameter int unsigned ROUNDS       = 4,
  parameter int unsigned WARN_FRAMES  = 60,
  parameter int unsigned FIRE_FRAMES  = 30,
  parameter logic [3:0]  SEL_CODE     = SEL_LASERS_SWEEP,
  parameter logic [11:0] COLOR_WARN   = COLOR_WARN_DEF,
  parameter logic [11:0] COLOR_FIRE   = COLOR_FIRE_DEF
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] vcount_in,
  input  logic [11:0] hcount_in,
  input  logic [11:0] rgb_in,
  input  logic        game_on,
  input  logic        menu_on,
  input  logic [3:0]  obstacle_sel,
  output logic [11:0] rgb_out,
  output logic [11:0] obstacle_x,
  output logic [11:0] obstacle_y,
  output logic        laser_hot,
  output logic        done
);

  localparam int unsigned MAX_FRAMES = (WARN_FRAMES > FIRE_FRAMES) ? WARN_FRAMES : FIRE_FRAMES;
  localparam int unsigned CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int unsigned RW         = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int unsigned MAX_RIGHT  = ARENA_LEFT + (ROUNDS - 1) * OFFSET_STEP
                                     + (N_LASERS - 1) * SPACING + LASER_WIDTH - 1;

  localparam logic [CNT_W-1:0] WARN_LOAD  = CNT_W'(WARN_FRAMES - 1);
  localparam logic [CNT_W-1:0] FIRE_LOAD  = CNT_W'(FIRE_FRAMES - 1);
  localparam logic [RW-1:0]    LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [11:0]      STEP       = 12'(OFFSET_STEP);
  localparam logic [11:0]      TOP_Y      = 12'(LASER_TOP);
  localparam logic [11:0]      BOTTOM_Y   = 12'(LASER_BOTTOM);

  // Geometry is computed in 12 bits with no wrap handling, so bad
  // parameter sets are rejected at elaboration.
  if (N_LASERS < 1 || N_LASERS > 8) begin : g_bad_count
    $error("lasers_sweep_obstacle: N_LASERS must be 1..8");
  end
  if (ROUNDS < 1 || WARN_FRAMES < 1 || FIRE_FRAMES < 1) begin : g_bad_timing
    $error("lasers_sweep_obstacle: ROUNDS and frame counts must be >= 1");
  end
  if (MAX_RIGHT > SCREEN_MAX_X || LASER_WIDTH < 1) begin : g_bad_geometry
    $error("lasers_sweep_obstacle: rightmost laser edge exceeds 12-bit range");
  end

  obstacle_state_e      state_q, state_d;
  logic [RW-1:0]        round_q, round_d;
  logic                 round_inc;
  logic                 t_load, t_clr, t_tc;
  logic [CNT_W-1:0]     t_val;
  logic [N_LASERS-1:0]  hit_vec;
  logic                 in_band;
  logic                 active;
  logic [11:0]          left0;
  logic [11:0]          pix;

  laser_frame_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .pclk      (pclk),
    .rst       (rst),
    .hcount_in (hcount_in),
    .vcount_in (vcount_in),
    .load      (t_load),
    .clr       (t_clr),
    .load_val  (t_val),
    .tc        (t_tc)
  );

  // State and round registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Next-state logic; menu abort overrides start and phase transitions.
  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    round_inc = 1'b0;
    t_load    = 1'b0;
    t_clr     = 1'b0;
    t_val     = '0;
    if (state_q != ST_IDLE && menu_on) begin
      state_d = ST_IDLE;
      round_d = '0;
      t_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (game_on && !menu_on && obstacle_sel == SEL_CODE) begin
            state_d = ST_WARN;
            round_d = '0;
            t_load  = 1'b1;
            t_val   = WARN_LOAD;
          end
        end
        ST_WARN: begin
          if (t_tc) begin
            state_d = ST_FIRE;
            t_load  = 1'b1;
            t_val   = FIRE_LOAD;
          end
        end
        ST_FIRE: begin
          if (t_tc) begin
            if (round_q == LAST_ROUND) begin
              state_d = ST_DONE;
              t_clr   = 1'b1;
            end else begin
              state_d   = ST_WARN;
              round_d   = round_q + 1'b1;
              round_inc = 1'b1;
              t_load    = 1'b1;
              t_val     = WARN_LOAD;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          round_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign in_band = (vcount_in >= TOP_Y) && (vcount_in <= BOTTOM_Y);

  // Column bounds live in registers: reloaded to the round-0 position while
  // idle and advanced by one step per round, so no per-pixel multiply.
  for (genvar gi = 0; gi < N_LASERS; gi++) begin : g_col
    localparam logic [11:0] BASE_L = 12'(ARENA_LEFT + gi * SPACING);
    localparam logic [11:0] BASE_R = 12'(ARENA_LEFT + gi * SPACING + LASER_WIDTH - 1);

    logic [11:0] left_q, right_q;

    // Hold or advance this column's bounds.
    always_ff @(posedge pclk) begin
      if (rst || state_q == ST_IDLE) begin
        left_q  <= BASE_L;
        right_q <= BASE_R;
      end else if (round_inc) begin
        left_q  <= left_q + STEP;
        right_q <= right_q + STEP;
      end
    end

    assign hit_vec[gi] = in_band && (hcount_in >= left_q) && (hcount_in <= right_q);

    if (gi == 0) begin : g_first
      assign left0 = left_q;
    end
  end

  // Pixel overlay colour for the current state.
  always_comb begin
    pix = rgb_in;
    if (|hit_vec) begin
      if (state_q == ST_WARN)      pix = COLOR_WARN;
      else if (state_q == ST_FIRE) pix = COLOR_FIRE;
    end
  end

  // Registered outputs, aligned with the state register.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_out   <= 12'h000;
      laser_hot <= 1'b0;
      done      <= 1'b0;
    end else begin
      rgb_out   <= pix;
      laser_hot <= (state_d == ST_FIRE);
      done      <= (state_d == ST_DONE);
    end
  end

  assign active     = (state_q == ST_WARN) || (state_q == ST_FIRE);
  assign obstacle_x = active ? left0 : 12'h000;
  assign obstacle_y = active ? TOP_Y : 12'h000;

endmodule

// File: doc/lasers_sweep_obstacle.md
Name: lasers_sweep_obstacle

Overview:
Parametrised successor to the single static laser obstacle. Draws N vertical laser columns inside the arena, driven by a frame-paced state machine. Each round has a non-lethal warning phase followed by a lethal fire phase, and the columns shift right by a fixed step every round. Sits in the rgb pixel chain between background/arena drawing and the player sprite, and reports laser state to the collision logic and to the obstacle sequencer.

Parameters:
N_LASERS, 3, number of laser columns (1..8)
LASER_WIDTH, 31, column width in pixels
LASER_TOP, 317, first lit row (inclusive)
LASER_BOTTOM, 617, last lit row (inclusive)
ARENA_LEFT, 341, left edge of laser 0 in round 0
SPACING, 100, left-to-left distance between adjacent lasers
OFFSET_STEP, 20, rightward shift applied per round
ROUNDS, 4, warn/fire rounds per activation
WARN_FRAMES, 60, frames spent in WARN
FIRE_FRAMES, 30, frames spent in FIRE
SEL_CODE, 4'b0011, obstacle_sel value that starts this obstacle
COLOR_WARN, 12'hf_8_0, warning colour
COLOR_FIRE, 12'hf_f_f, firing colour

Ports:
pclk  in  1  pixel clock; single clock domain
rst  in  1  synchronous, active-high reset
vcount_in  in  12  current pixel row
hcount_in  in  12  current pixel column
rgb_in  in  12  upstream pixel colour
game_on  in  1  game running
menu_on  in  1  menu active; aborts the obstacle
obstacle_sel  in  4  obstacle chosen by the sequencer
rgb_out  out  12  output pixel colour (registered)
obstacle_x  out  12  left x of laser 0 in the current round
obstacle_y  out  12  top y of the laser band
laser_hot  out  1  high while in FIRE (lethal)
done  out  1  one-cycle pulse when the final round ends

Behaviour:
- Clock and reset: one clock, pclk. rst is synchronous and active-high.
- Reset values: state=IDLE; rgb_out=0; obstacle_x=0; obstacle_y=0; laser_hot=0; done=0; frame and round counters=0.
- Frame tick: registered 1-cycle pulse, generated when hcount_in==0 && vcount_in==0.
- States: IDLE, WARN, FIRE, DONE.
- IDLE -> WARN on the next cycle when game_on && obstacle_sel==SEL_CODE. Entering WARN clears the frame counter and sets round=0.
- WARN: count frame ticks. On the tick where frame_cnt==WARN_FRAMES-1, go to FIRE and clear frame_cnt.
- FIRE: count frame ticks. On the tick where frame_cnt==FIRE_FRAMES-1:
  - if round==ROUNDS-1, go to DONE;
  - otherwise round+1, frame_cnt=0, go to WARN.
- DONE: exactly one cycle, with done=1. Then IDLE.
- Abort: menu_on high in any non-IDLE state forces IDLE on the next cycle and clears all counters. menu_on wins over a simultaneous start condition and over any simultaneous phase transition. rst wins over everything.
- Geometry for laser i, round r:
  - left_i = ARENA_LEFT + r*OFFSET_STEP + i*SPACING
  - right_i = left_i + LASER_WIDTH - 1
  - Arithmetic is unsigned 12-bit. Parameters must keep right_{N-1} at round ROUNDS-1 below 4096; elaboration-time check, no wrap handling.
- Pixel hit: LASER_TOP <= vcount_in <= LASER_BOTTOM and left_i <= hcount_in <= right_i, for any i. All comparisons are inclusive. Overlapping columns are a plain OR.
- rgb_out latency is 1 cycle from hcount_in/vcount_in/rgb_in:
  - COLOR_WARN on a hit in WARN;
  - COLOR_FIRE on a hit in FIRE;
  - rgb_in otherwise, including IDLE and DONE.
- laser_hot is registered and equals (state==FIRE).
- obstacle_x = left_0 and obstacle_y = LASER_TOP while in WARN or FIRE; both are 0 in IDLE and DONE.
- Column bounds are recomputed only when round changes, and held in registers. No per-pixel multiply.

Decomposition:
- Shared package obstacle_pkg holds:
  - state encoding;
  - arena bound constants;
  - COLOR_WARN/COLOR_FIRE defaults;
  - obstacle select codes.
- One sub-module, laser_frame_timer: frame-tick detect plus a loadable frame counter with a terminal-count flag. It is instantiated once; the FSM chooses WARN_FRAMES or FIRE_FRAMES as the limit.

Test Plan:
All scenarios use N_LASERS=3, WARN_FRAMES=2, FIRE_FRAMES=3, ROUNDS=2, other parameters at default.
1. Reset asserted for 3 cycles -> rgb_out=0, obstacle_x=0, obstacle_y=0, laser_hot=0, done=0. With game_on=0, rgb_out tracks rgb_in with 1-cycle latency.
2. game_on=1, obstacle_sel=3 -> state WARN:
   - pixel (341,317) and (371,617) -> rgb_out=12'hf80;
   - (372,400), (340,400) and (341,316) -> rgb_out=rgb_in;
   - obstacle_x=341, obstacle_y=317.
3. After 2 frame ticks -> FIRE and laser_hot=1; (441,400) and (541,400) -> 12'hfff.
4. Round 1 -> obstacle_x=361 and (361,400) lit while (341,400) passes through. After the third FIRE tick -> done high for exactly one cycle, then IDLE with laser_hot=0.
5. menu_on pulsed mid-FIRE -> IDLE next cycle, laser_hot=0, rgb passthrough. A restart begins at round 0 with obstacle_x=341.
6. game_on=1 with obstacle_sel=4'b0101 -> stays IDLE for 10 frames; menu_on coinciding with a valid start -> stays IDLE.
